// File: rtl/seq_detect_pkg.sv
// Shared types and the single-step "0101" Mealy detector used by seq_detect_scheduler.
// Overlapping matches: a completed "0101" leaves the detector in S2 ("01" seen).
package seq_detect_pkg;

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } seq_state_t;

  typedef struct packed {
    seq_state_t next_state;
    logic       match;
  } seq_step_t;

  function automatic seq_step_t seq_step(input seq_state_t state, input logic in_bit);
    seq_step_t r;
    r.match = 1'b0;
    case (state)
      S0:      r.next_state = in_bit ? S0 : S1;
      S1:      r.next_state = in_bit ? S2 : S1;
      S2:      r.next_state = in_bit ? S0 : S3;
      default: begin
        r.next_state = in_bit ? S2 : S1;
        r.match      = in_bit;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seq_detect_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from the pointer with wrap-around;
// the pointer advances past the granted channel and holds when nothing is requested.
module rr_arbiter #(
  parameter int  NUM_CH = 4,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] req,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   grant_idx,
  output logic              grant_any
);

  logic [CH_W-1:0] ptr_reg;
  logic [CH_W-1:0] ptr_next;

  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    for (int off = 0; off < NUM_CH; off++) begin
      idx = int'(ptr_reg) + off;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!grant_any && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = CH_W'(idx);
        grant_any  = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_next = ptr_reg;
    if (grant_any) begin
      ptr_next = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_reg <= '0;
    else       ptr_reg <= ptr_next;
  end

endmodule

// File: rtl/seq_detect_scheduler.sv
// Time-shared "0101" detector over NUM_CH serial lanes with per-channel state file.
// Optional per-channel saturating match counters with readback: define SEQ_MATCH_COUNT_EN.
module seq_detect_scheduler
  import seq_detect_pkg::*;
#(
  parameter int  NUM_CH = 4,
  parameter int  MCNT_W = 8,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ch_valid,
  input  logic [NUM_CH-1:0] ch_bit,
  output logic [NUM_CH-1:0] ch_ready,
  input  logic [NUM_CH-1:0] ch_clear,
  output logic              match_valid,
  output logic [CH_W-1:0]   match_ch,
`ifdef SEQ_MATCH_COUNT_EN
  input  logic [CH_W-1:0]   cnt_sel,
  output logic [MCNT_W-1:0] cnt_val,
`endif
  output logic              busy
);

  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] grant;
  logic [CH_W-1:0]   grant_idx;
  logic              grant_any;
  seq_state_t        state_reg  [NUM_CH];
  seq_state_t        state_next [NUM_CH];
  logic [NUM_CH-1:0] active_next;
  seq_step_t         step;
  logic              hit;

  // Reset gates requests so no grant is offered while the state file is held.
  assign req = ch_valid & ~ch_clear & {NUM_CH{~reset}};

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign ch_ready = grant;
  assign step     = seq_step(state_reg[grant_idx], ch_bit[grant_idx]);
  assign hit      = grant_any & step.match;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      // A cleared channel is never granted, so clear and step never collide.
      assign state_next[gi]  = ch_clear[gi] ? S0 :
                               (grant[gi] ? step.next_state : state_reg[gi]);
      assign active_next[gi] = (state_next[gi] != S0);
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) state_reg[i] <= S0;
      match_valid <= 1'b0;
      match_ch    <= '0;
      busy        <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) state_reg[i] <= state_next[i];
      match_valid <= hit;
      if (hit) match_ch <= grant_idx;
      busy <= |active_next;
    end
  end

`ifdef SEQ_MATCH_COUNT_EN
  logic [MCNT_W-1:0] cnt_reg [NUM_CH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) cnt_reg[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_clear[i])
          cnt_reg[i] <= '0;
        else if (grant[i] && step.match && !(&cnt_reg[i]))
          cnt_reg[i] <= cnt_reg[i] + MCNT_W'(1);
      end
    end
  end

  // Select by compare so out-of-range selects read zero without indexing past the file.
  always_comb begin
    cnt_val = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(cnt_sel) == i) cnt_val = cnt_reg[i];
    end
  end
`endif

endmodule
